scaled_line_fetcher: RTL and testbench

Parametrised successor of the two-line display fetcher in the VESA cellular-automaton path. It reads packed pixel words from the line RAM one word ahead of the beam and shifts them out as a 1-bit image stream. It sits between the sync/counter generator and the colour output. New over the previous generation:
- generic word width and line length
- N line banks instead of a parity bit
- configurable RAM read latency through a staging register
- integer pixel scaling (2^SCALE clocks per pixel)
- selectable bit order
- sticky underrun detection

---
 rtl/line_fetch_pkg.sv | 24 ++
 rtl/pixel_shift_reg.sv | 27 ++
 rtl/scaled_line_fetcher.sv | 103 ++++++++++
 tb/tb_scaled_line_fetcher.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fetch_pkg.sv
// Shared constants and helpers for the scaled line fetcher.
// The phase constants describe where in a word span the fetch and load happen.
package line_fetch_pkg;

  localparam int DEF_WORD_W         = 16;
  localparam int DEF_WORDS_PER_LINE = 80;
  localparam int DEF_NUM_BANKS      = 2;
  localparam int DEF_SCALE          = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int load_phase(input int scale, input int word_w);
    return (1 << (scale + clog2(word_w))) - 1;
  endfunction

  localparam int READ_PHASE = 0;
  localparam int LOAD_PHASE = load_phase(DEF_SCALE, DEF_WORD_W);

endpackage

// File: rtl/pixel_shift_reg.sv
// Output shifter: parallel load of one pixel word, then one bit per pixel
// toward the display end, zero-filled.
module pixel_shift_reg
  import line_fetch_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_word,
  output logic              out_bit
);

  logic [WORD_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= load_word;
    else if (shift) sr <= MSB_FIRST ? (sr << 1) : (sr >> 1);
  end

  assign out_bit = MSB_FIRST ? sr[WORD_W-1] : sr[0];

endmodule

// File: rtl/scaled_line_fetcher.sv
// Fetches one packed pixel word per span, one span ahead of the beam, and
// streams it out as a 1-bit image with integer pixel scaling.
module scaled_line_fetcher
  import line_fetch_pkg::*;
#(
  parameter int WORD_W         = DEF_WORD_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int NUM_BANKS      = DEF_NUM_BANKS,
  parameter int ADDR_W         = 8,
  parameter int X_W            = 11,
  parameter int RD_LAT         = 1,
  parameter int SCALE          = DEF_SCALE,
  parameter bit MSB_FIRST      = 1'b1,
  localparam int LS_W          = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [X_W-1:0]    CounterX,
  input  logic [LS_W-1:0]   line_sel,
  input  logic              inDisplayArea,
  input  logic              inPrefetchArea,
  input  logic              clr_underrun,
  output logic              read,
  output logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data,
  output logic              image,
  output logic              underrun
);

  localparam int PW      = SCALE + clog2(WORD_W);
  localparam int LOAD_PH = load_phase(SCALE, WORD_W);
  localparam int CAP_PH  = READ_PHASE + 1 + RD_LAT;
  localparam int PIX     = 1 << SCALE;

  logic [PW-1:0]     phase;
  logic [X_W-1:0]    widx;
  logic [LS_W-1:0]   bank;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WORD_W-1:0] stage;
  logic              valid, issued, in_range;
  logic              at_read, at_cap, at_load, pix_end, load, out_bit;

  assign phase      = CounterX[PW-1:0];
  assign widx       = CounterX >> PW;
  assign in_range   = int'(widx) < WORDS_PER_LINE;
  assign bank       = (int'(line_sel) < NUM_BANKS) ? line_sel : '0;
  assign fetch_addr = ADDR_W'(int'(bank) * WORDS_PER_LINE + int'(widx));
  assign at_read    = int'(phase) == READ_PHASE;
  assign at_cap     = int'(phase) == CAP_PH;
  assign at_load    = int'(phase) == LOAD_PH;
  assign pix_end    = (int'(phase) % PIX) == PIX - 1;
  assign load       = inPrefetchArea && at_load;

  // issued marks a read in flight for this span; dropping the prefetch
  // window kills both the in-flight read and any staged word.
  always_ff @(posedge clk) begin
    if (rst) begin
      read     <= 1'b0;
      addr     <= '0;
      stage    <= '0;
      valid    <= 1'b0;
      issued   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      read <= 1'b0;
      if (!inPrefetchArea) begin
        valid  <= 1'b0;
        issued <= 1'b0;
      end else if (at_read) begin
        if (in_range) begin
          read   <= 1'b1;
          addr   <= fetch_addr;
          issued <= 1'b1;
        end else begin
          stage  <= '0;
          valid  <= 1'b1;
          issued <= 1'b0;
        end
      end else if (at_cap && issued) begin
        stage  <= data;
        valid  <= 1'b1;
        issued <= 1'b0;
      end else if (at_load) begin
        valid  <= 1'b0;
        issued <= 1'b0;
      end
      if (load && !valid)    underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

  pixel_shift_reg #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (pix_end),
    .load_word(valid ? stage : '0),
    .out_bit  (out_bit)
  );

  assign image = inDisplayArea && out_bit;

endmodule

// File: tb/tb_scaled_line_fetcher.sv
// Bench for scaled_line_fetcher: four configurations share one beam; a
// span-level model predicts read/addr/image/underrun every cycle.
module tb_scaled_line_fetcher;

  localparam int SP[4] = '{16, 32, 16, 16};
  localparam int SC[4] = '{0, 1, 0, 0};
  localparam int RL[4] = '{1, 1, 3, 1};
  localparam int MF[4] = '{1, 1, 1, 0};
  localparam int NB[4] = '{2, 2, 2, 3};

  logic        clk;
  logic        rst, clr;
  logic [1:0]  ls;
  logic [10:0] cx;
  int          X;
  logic        pf[4], dp[4], rd[4], img[4], und[4];
  logic [7:0]  ad[4];
  logic [15:0] dat[4];

  int          pf_end[4], gap[4];
  logic        late[4];
  logic        cen;
  logic [15:0] cval[4];
  int          rst_x, clr_a, clr_b;
  logic        armed;

  int vectors, errs;

  // model state
  logic        m_rd[4], m_und[4], m_ok[4];
  int          m_ad[4];
  logic [15:0] m_dw[4], m_v[4];

  // run accumulators
  int          rdcnt[4], rda[4], rdx[4];
  logic [15:0] v0, v2, v3;
  logic [31:0] v1;
  logic        s_rd[128], s_img[128], s_und[128];
  int          s_ad[128];

  // RAM read history
  logic [4:0]  hrd[4];
  logic [7:0]  had[4][5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign cx = 11'(X);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pf[i] = (X < pf_end[i]) && (X != gap[i]);
      dp[i] = (X >= SP[i]) && (X < pf_end[i] + SP[i]);
    end
  end

  function automatic logic [15:0] ram_word(input int i, input logic [7:0] a);
    return cen ? cval[i] : {8'h00, a};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) hrd[i] <= '0;
      else     hrd[i] <= {hrd[i][3:0], rd[i]};
      had[i][0] <= ad[i];
      for (int j = 1; j < 5; j++) had[i][j] <= had[i][j-1];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dat[i] = '0;
      if (hrd[i][RL[i] - 1 + int'(late[i])])
        dat[i] = ram_word(i, had[i][RL[i] - 1 + int'(late[i])]);
    end
  end

  scaled_line_fetcher u0 (
    .clk(clk), .rst(rst), .CounterX(cx), .line_sel(ls[0]),
    .inDisplayArea(dp[0]), .inPrefetchArea(pf[0]), .clr_underrun(clr),
    .read(rd[0]), .addr(ad[0]), .data(dat[0]), .image(img[0]), .underrun(und[0]));

  scaled_line_fetcher #(.SCALE(1)) u1 (
    .clk(clk), .rst(rst), .CounterX(cx), .line_sel(ls[0]),
    .inDisplayArea(dp[1]), .inPrefetchArea(pf[1]), .clr_underrun(clr),
    .read(rd[1]), .addr(ad[1]), .data(dat[1]), .image(img[1]), .underrun(und[1]));

  scaled_line_fetcher #(.RD_LAT(3)) u2 (
    .clk(clk), .rst(rst), .CounterX(cx), .line_sel(ls[0]),
    .inDisplayArea(dp[2]), .inPrefetchArea(pf[2]), .clr_underrun(clr),
    .read(rd[2]), .addr(ad[2]), .data(dat[2]), .image(img[2]), .underrun(und[2]));

  scaled_line_fetcher #(.MSB_FIRST(1'b0), .NUM_BANKS(3)) u3 (
    .clk(clk), .rst(rst), .CounterX(cx), .line_sel(ls),
    .inDisplayArea(dp[3]), .inPrefetchArea(pf[3]), .clr_underrun(clr),
    .read(rd[3]), .addr(ad[3]), .data(dat[3]), .image(img[3]), .underrun(und[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Span-level model: the word fetched in span w is shown in span w+1;
  // a load with nothing fetched shows zeros and raises underrun.
  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int ph, w, lsi, bank;
      logic set;
      if (rst) begin
        m_rd[i] = 0; m_ad[i] = 0; m_dw[i] = '0; m_ok[i] = 0; m_und[i] = 0;
        continue;
      end
      ph = X % SP[i];
      w = X / SP[i];
      lsi = (NB[i] == 2) ? int'(ls[0]) : int'(ls);
      bank = (lsi < NB[i]) ? lsi : 0;
      m_rd[i] = 0;
      set = 0;
      if (ph == SP[i] - 1) m_dw[i] = '0;
      if (!pf[i]) m_ok[i] = 0;
      else if (ph == 0) begin
        m_ok[i] = 1;
        if (w < 80) begin
          m_rd[i] = 1;
          m_ad[i] = bank * 80 + w;
          m_v[i] = late[i] ? 16'h0 : ram_word(i, 8'(m_ad[i]));
        end else m_v[i] = '0;
      end else if (ph == SP[i] - 1) begin
        if (m_ok[i]) m_dw[i] = m_v[i];
        else set = 1;
        m_ok[i] = 0;
      end
      m_und[i] = set ? 1'b1 : (clr ? 1'b0 : m_und[i]);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        logic eb;
        k = (X % SP[i]) >> SC[i];
        eb = dp[i] && (MF[i] != 0 ? m_dw[i][15-k] : m_dw[i][k]);
        chk($sformatf("u%0d_read@x%0d", i, X), 32'(rd[i]), 32'(m_rd[i]));
        chk($sformatf("u%0d_addr@x%0d", i, X), 32'(ad[i]), 32'(m_ad[i]));
        chk($sformatf("u%0d_image@x%0d", i, X), 32'(img[i]), 32'(eb));
        chk($sformatf("u%0d_underrun@x%0d", i, X), 32'(und[i]), 32'(m_und[i]));
      end
    end
  end

  task automatic sample();
    for (int i = 0; i < 4; i++)
      if (rd[i]) begin rdcnt[i]++; rda[i] = ad[i]; rdx[i] = X; end
    if (X >= 16 && X < 32) begin
      v0 = {v0[14:0], img[0]}; v2 = {v2[14:0], img[2]}; v3 = {v3[14:0], img[3]};
    end
    if (X >= 32 && X < 64) v1 = {v1[30:0], img[1]};
    if (X < 128) begin
      s_rd[X] = rd[0]; s_ad[X] = ad[0]; s_img[X] = img[0]; s_und[X] = und[0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int nx, input int pfw);
    for (int i = 0; i < 4; i++) begin
      pf_end[i] = pfw * SP[i]; rdcnt[i] = 0; rda[i] = -1; rdx[i] = -1;
    end
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    for (int x = 0; x < nx; x++) begin
      X = x;
      rst = (x == rst_x);
      clr = (x == clr_a) || (x == clr_b);
      tick();
    end
    rst = 0; clr = 0;
  endtask

  initial begin
    vectors = 0; errs = 0; armed = 0;
    X = 0; rst = 1; clr = 0; ls = 2'd1; cen = 1;
    rst_x = -1; clr_a = -1; clr_b = -1;
    cval[0] = 16'hA5F0; cval[1] = 16'h8001; cval[2] = 16'hA5F0; cval[3] = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      pf_end[i] = 0; gap[i] = -1; late[i] = 0;
      m_rd[i] = 0; m_ad[i] = 0; m_dw[i] = '0; m_ok[i] = 0; m_und[i] = 0; m_v[i] = '0;
    end
    tick();
    armed = 1;
    tick();
    chk("reset_read", 32'(rd[0]), 0);
    chk("reset_underrun", 32'(und[0]), 0);
    rst = 0;

    // single word on bank 1 for every configuration
    run(80, 1);
    chk("t1_read_count", rdcnt[0], 1);
    chk("t1_read_x", rdx[0], 1);
    chk("t1_addr", rda[0], 80);
    chk("t1_image", 32'(v0), 32'hA5F0);
    chk("t3_image", v1, 32'hC0000003);
    chk("t4_image_rdlat3", 32'(v2), 32'hA5F0);
    chk("t5_image_lsb_first", 32'(v3), 32'hC000);
    chk("t5_addr_bank1", rda[3], 80);

    // full line bank 0, RAM returns its address, runs past the line end
    ls = 2'd0; cen = 0;
    run(1340, 82);
    chk("t2_read_count", rdcnt[0], 80);
    chk("t2_last_addr", rda[0], 79);
    chk("t2_last_read_x", rdx[0], 1265);
    chk("t2_scale1_reads", rdcnt[1], 42);
    chk("t2_underrun", 32'(und[0]), 0);

    // late RAM data: zero captured, no underrun
    ls = 2'd1; cen = 1; late[2] = 1;
    run(48, 1);
    chk("t4_late_image", 32'(v2), 0);
    chk("t4_late_underrun", 32'(und[2]), 0);

    // prefetch dropped on the capture edge: underrun; line_sel 3 -> bank 0
    late[2] = 0; gap[2] = 4; gap[0] = 2; ls = 2'd3;
    run(48, 1);
    chk("t4_miss_underrun", 32'(und[2]), 1);
    chk("t4_miss_image", 32'(v2), 0);
    chk("t6_pre_underrun", 32'(und[0]), 1);
    chk("bank_oob_addr", rda[3], 0);

    // mid-word reset, then underrun set colliding with clear
    gap[0] = -1; gap[2] = -1; ls = 2'd1;
    rst_x = 24; clr_a = 31; clr_b = 40;
    run(80, 3);
    chk("t6_img_before", 32'(s_img[24]), 1);
    chk("t6_und_before", 32'(s_und[24]), 1);
    chk("t6_read_after", 32'(s_rd[25]), 0);
    chk("t6_addr_after", s_ad[25], 0);
    chk("t6_img_after", 32'(s_img[25]), 0);
    chk("t6_und_after", 32'(s_und[25]), 0);
    chk("t6_set_beats_clr", 32'(s_und[32]), 1);
    chk("t6_refetch_read", 32'(s_rd[33]), 1);
    chk("t6_refetch_addr", s_ad[33], 82);
    chk("t6_clr", 32'(s_und[41]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
